// File: rtl/dlfloat_dot_seq_if.sv
// ---------------------------------------------------------------------------
// dlfloat_dot_seq_if
//   Signal bundle for the DLFloat16 dot-product sequencer. It carries the run
//   request, the operand stream, the MAC-facing datapath and the result port.
//
//   Modports:
//     master : environment side. It issues start/vec_len, supplies operand
//              pairs, returns the MAC accumulator value and consumes results.
//     slave  : the sequencer (dlfloat_dot_seq).
//
//   Parameter:
//     LEN_W  : width of vec_len. It must match the sequencer's LEN_W.
// ---------------------------------------------------------------------------
interface dlfloat_dot_seq_if #(
  parameter int LEN_W = 8
);
  // Run control
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             busy;

  // Operand stream
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             in_valid;
  logic             in_ready;

  // MAC datapath
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_clr;
  logic [15:0]      mac_result;

  // Result port
  logic [15:0]      res_data;
  logic             res_valid;
  logic             res_ready;
  logic             res_nan;

  modport master (
    output start, vec_len, in_a, in_b, in_valid, mac_result, res_ready,
    input  busy, in_ready, mac_a, mac_b, mac_clr, res_data, res_valid, res_nan
  );

  modport slave (
    input  start, vec_len, in_a, in_b, in_valid, mac_result, res_ready,
    output busy, in_ready, mac_a, mac_b, mac_clr, res_data, res_valid, res_nan
  );
endinterface

// File: rtl/dlfloat_dot_seq.sv
// ---------------------------------------------------------------------------
// dlfloat_dot_seq
//   This sequencer drives a DLFloat16 MAC (registered multiplier feeding a
//   registered accumulator) to compute a dot product of vec_len pairs. For
//   each run it clears the accumulator, streams the operand pairs into the MAC
//   one per cycle, waits out the MAC latency, captures the sum and holds it on
//   a valid/ready result port.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset. It aborts any run.
//     bus    : dlfloat_dot_seq_if.slave
//              start/vec_len          run request, sampled only in IDLE
//              in_a/in_b/in_valid/in_ready   operand stream, accepted in LOAD
//              mac_a/mac_b/mac_clr    registered MAC operands and clear
//              mac_result             MAC accumulator output
//              res_data/res_valid/res_ready/res_nan   result port
//              busy                   high whenever the state is not IDLE
//
//   Parameters:
//     LEN_W   : width of vec_len and of the remaining-element counter
//     MAC_LAT : cycles from operands at the MAC inputs until the product is
//               visible in mac_result
//
//   Optional feature (macro DLF_NAN_FLAG_EN):
//     When the macro is defined, a sticky flag records any accepted 16'hFFFF
//     operand. It is combined with a 16'hFFFF mac_result to assert res_nan,
//     and when res_nan is set, res_data is forced to 16'hFFFF. When the macro
//     is undefined, res_nan is tied low and res_data is mac_result unmodified.
// ---------------------------------------------------------------------------
module dlfloat_dot_seq #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  dlfloat_dot_seq_if.slave bus
);

  localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   remaining, remaining_nx;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nx;

  logic [15:0]        mac_a_q, mac_a_nx;
  logic [15:0]        mac_b_q, mac_b_nx;
  logic               mac_clr_q, mac_clr_nx;
  logic [15:0]        res_data_q, res_data_nx;

  logic               xfer;        // operand pair accepted this cycle
  logic               empty_run;   // start with vec_len == 0
  logic               capture;     // last drain cycle: sample mac_result

`ifdef DLF_NAN_FLAG_EN
  logic               nan_flag, nan_flag_nx;
  logic               res_nan_q, res_nan_nx;
`endif

  assign xfer      = (state == S_LOAD) && bus.in_valid;
  assign empty_run = (state == S_IDLE) && bus.start && (bus.vec_len == '0);
  assign capture   = (state == S_DRAIN) && (drain_cnt == '0);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: every register that drives an output is reset here. This lets an
  // abort leave the MAC inputs and the result port quiet right away, without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      remaining  <= '0;
      drain_cnt  <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_clr_q  <= 1'b0;
      res_data_q <= '0;
`ifdef DLF_NAN_FLAG_EN
      nan_flag   <= 1'b0;
      res_nan_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // pre-edge values, so the statement order in this block does not matter.
      state      <= state_nx;
      remaining  <= remaining_nx;
      drain_cnt  <= drain_cnt_nx;
      mac_a_q    <= mac_a_nx;
      mac_b_q    <= mac_b_nx;
      mac_clr_q  <= mac_clr_nx;
      res_data_q <= res_data_nx;
`ifdef DLF_NAN_FLAG_EN
      nan_flag   <= nan_flag_nx;
      res_nan_q  <= res_nan_nx;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: each variable gets a default before the case statement, so a
    // branch that skips an assignment holds the value instead of inferring a
    // latch.
    state_nx     = state;
    remaining_nx = remaining;
    drain_cnt_nx = drain_cnt;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.vec_len != '0) begin
            remaining_nx = bus.vec_len;
            state_nx     = S_CLR;
          end else begin
            state_nx     = S_RESULT;
          end
        end
      end

      S_CLR: state_nx = S_LOAD;

      S_LOAD: begin
        if (xfer) begin
          remaining_nx = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            // The last pair's product needs MAC_LAT edges to reach
            // mac_result. Capture happens on the edge after that.
            drain_cnt_nx = DRAIN_W'(MAC_LAT);
            state_nx     = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nx     = S_RESULT;
        end else begin
          drain_cnt_nx = drain_cnt - DRAIN_W'(1);
        end
      end

      S_RESULT: begin
        if (bus.res_ready) state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values of the registered MAC and result outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // A cycle without a transfer feeds 0 x 0. This adds nothing to the
    // accumulator, so bubbles in the input stream are harmless.
    mac_a_nx    = xfer ? bus.in_a : 16'h0000;
    mac_b_nx    = xfer ? bus.in_b : 16'h0000;
    mac_clr_nx  = (state == S_IDLE) && (state_nx == S_CLR);
    res_data_nx = res_data_q;
`ifdef DLF_NAN_FLAG_EN
    res_nan_nx  = res_nan_q;
    nan_flag_nx = nan_flag;
    if (mac_clr_nx) begin
      nan_flag_nx = 1'b0;
    end else if (xfer && ((bus.in_a == 16'hFFFF) || (bus.in_b == 16'hFFFF))) begin
      nan_flag_nx = 1'b1;
    end
`endif

    if (empty_run) begin
      res_data_nx = 16'h0000;
`ifdef DLF_NAN_FLAG_EN
      res_nan_nx  = 1'b0;
`endif
    end else if (capture) begin
`ifdef DLF_NAN_FLAG_EN
      res_nan_nx  = nan_flag || (bus.mac_result == 16'hFFFF);
      res_data_nx = res_nan_nx ? 16'hFFFF : bus.mac_result;
`else
      res_data_nx = bus.mac_result;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Port drive
  // -------------------------------------------------------------------------
  assign bus.in_ready  = (state == S_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.res_valid = (state == S_RESULT);
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.res_data  = res_data_q;
`ifdef DLF_NAN_FLAG_EN
  assign bus.res_nan   = res_nan_q;
`else
  assign bus.res_nan   = 1'b0;
`endif

endmodule

// File: doc/dlfloat_dot_seq.md
Name: dlfloat_dot_seq

Overview:
- Sequencer that drives the DLFloat16 MAC datapath (registered multiplier feeding a registered accumulating adder) to compute dot products of programmable length.
- Accepts operand pairs over a valid/ready stream and feeds them to the MAC one pair per cycle.
- Clears the accumulator before each run, waits out the pipeline latency, captures the result and presents it on a valid/ready result port.
- Sits between the chip's I/O wrappers and the MAC instance.

Parameters:
LEN_W, 8, width of vector-length input and element counter
MAC_LAT, 2, cycles from operands at MAC inputs to that product being included in mac_result (multiplier reg + accumulator reg)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a run; sampled only in IDLE
vec_len  in  LEN_W  number of operand pairs; latched on accepted start
in_a  in  16  DLFloat16 operand A
in_b  in  16  DLFloat16 operand B
in_valid  in  1  operand pair valid
in_ready  out  1  controller accepts pair this cycle
mac_a  out  16  registered operand A to MAC
mac_b  out  16  registered operand B to MAC
mac_clr  out  1  registered synchronous accumulator clear, active high
mac_result  in  16  accumulator output of MAC
res_data  out  16  captured dot-product result
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_nan  out  1  result is the 16'hFFFF NaN/Inf marker (see Optional Feature)
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `rst_n`. Reset forces state IDLE and drives every output to 0: in_ready, mac_a, mac_b, mac_clr, res_data, res_valid, res_nan, busy. Element counter and drain counter also reset to 0.
- States: IDLE, CLR, LOAD, DRAIN, RESULT.
- IDLE:
  - start=1 with vec_len!=0: latch vec_len into remaining counter, go to CLR.
  - start=1 with vec_len==0: set res_data=0, res_nan=0, go to RESULT (no MAC activity).
  - start is ignored in all other states.
- CLR: mac_clr=1 for exactly one cycle, mac_a=mac_b=0, in_ready=0. Next state LOAD.
- LOAD: in_ready=1.
  - On in_valid&in_ready: register mac_a<=in_a, mac_b<=in_b on that edge and decrement remaining.
  - Cycle without a transfer: mac_a<=0, mac_b<=0. A zero product is an accumulator no-op.
  - When the last pair transfers (remaining==1): in_ready drops in the next cycle, drain counter loads MAC_LAT, go to DRAIN.
- DRAIN: in_ready=0, mac_a=mac_b=0. Decrement drain counter each cycle. At 0, capture res_data<=mac_result and go to RESULT.
  - Total latency from the last pair's accept edge to res_valid high is MAC_LAT+1 cycles.
- RESULT: res_valid=1, res_data held stable until res_valid&res_ready. On that handshake: res_valid<=0, go to IDLE.
  - res_ready already high on entry completes the transfer in the first RESULT cycle.
- in_valid outside LOAD: ignored, no transfer.
- Counter arithmetic: unsigned LEN_W bits. vec_len=2^LEN_W-1 is legal and does not wrap.
- Reset mid-operation: immediate abort, state IDLE. The partially accumulated value is discarded; the next run begins with CLR.
- mac_clr is never asserted outside CLR.

Optional Feature:
- Macro: DLF_NAN_FLAG_EN.
- Defined:
  - The controller keeps a sticky flag, set in LOAD when an accepted in_a or in_b equals 16'hFFFF. It clears on entry to CLR.
  - At capture, res_nan<=flag | (mac_result==16'hFFFF). When res_nan=1, res_data is forced to 16'hFFFF.
- Undefined: res_nan is tied to 0 and res_data is mac_result unmodified; the flag logic is not built.

Test Plan:
- vec_len=1, pair (0x3E00, 0x3E00) i.e. 1.0×1.0 → in_ready for one transfer; res_valid high MAC_LAT+1 cycles after the accept edge; res_data=0x3E00.
- vec_len=3, pairs 1.0×1.0, 2.0×1.0, 1.0×1.0 with in_valid deasserted 2 cycles between pairs → zero bubbles on mac_a/b; res_data=0x4200 (4.0).
- Two back-to-back runs, second with vec_len=1 and pair 1.0×2.0 → mac_clr pulses once per run; second res_data=0x4000, no carry-over from the first run.
- start with vec_len=0 → RESULT next cycle, res_data=0, mac_clr never asserted.
- res_ready held low 5 cycles in RESULT → res_data and res_valid stable; start pulses during this window are ignored.
- rst_n low mid-LOAD → all outputs 0 asynchronously; new run with vec_len=1 and 1.0×1.0 gives 0x3E00. With DLF_NAN_FLAG_EN, in_a=0xFFFF in any pair → res_nan=1, res_data=0xFFFF.
